// File: rtl/sonar_ranger.sv
`default_nettype none
// ============================================================================
// Module   : sonar_ranger
// Purpose  : Ultrasonic range sensor driver for the cutting-machine
//            controller. A level request starts a timed sensor trigger
//            pulse, the echo pulse width is then measured and returned as a
//            range in millimetres. Echo timeout, over-long echo and the
//            minimum re-ping spacing are handled internally.
// Ports    : clk        - clock
//            rst_n      - asynchronous active-low reset
//            trigger    - measurement request (level, sampled in IDLE only)
//            triggerSuc - one-cycle pulse, sensor trigger pulse completed
//            valid      - one-cycle pulse, distance/timeout updated
//            distance   - range in mm, held between valid pulses
//            timeout    - last result was a timeout/abort, held
//            busy       - high whenever the FSM is not idle
//            sonar_trig - sensor trigger pin
//            sonar_echo - sensor echo pin (asynchronous)
// Revision : 1.0 - initial release
// ============================================================================
module sonar_ranger #(
    parameter int DisLen       = 16,
    parameter int TRIG_CYC     = 500,
    parameter int CYC_PER_MM   = 291,
    parameter int TIMEOUT_CYC  = 1500000,
    parameter int MAX_ECHO_CYC = 1250000,
    parameter int HOLDOFF_CYC  = 3000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trigger,
    output logic            triggerSuc,
    output logic            valid,
    output logic [DisLen:0] distance,
    output logic            timeout,
    output logic            busy,
    output logic            sonar_trig,
    input  logic            sonar_echo
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One cycle counter is shared by every timed state, so it is sized for
    // the largest of the timing parameters.
    localparam int c_CNT_MAX = max2(max2(TRIG_CYC, TIMEOUT_CYC),
                                    max2(MAX_ECHO_CYC, HOLDOFF_CYC));
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_PRE_W   = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TRIG_LAST   = c_CNT_W'(TRIG_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TOUT_LAST   = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_ECHO_LAST   = c_CNT_W'(MAX_ECHO_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST   = c_CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE     = c_PRE_W'(1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST    = c_PRE_W'(CYC_PER_MM - 1);
    localparam logic [DisLen:0]    c_ACC_ONE     = (DisLen+1)'(1);
    localparam logic [DisLen:0]    c_ALL_ONES    = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_ECHO      = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_PRE_W-1:0] r_pre;
    logic [DisLen:0]    r_acc;

    logic r_echo_meta;
    logic r_echo_sync;
    logic r_echo_prev;

    logic            w_echo_rise;
    logic            w_echo_fall;
    logic            w_pre_wrap;
    logic [DisLen:0] w_acc_next;

    // Two-flop synchronizer plus one delay stage for edge detection. Both
    // edges pass through the same delay, so the measured width is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo_meta <= 1'b0;
            r_echo_sync <= 1'b0;
            r_echo_prev <= 1'b0;
        end else begin
            r_echo_meta <= sonar_echo;
            r_echo_sync <= r_echo_meta;
            r_echo_prev <= r_echo_sync;
        end
    end

    assign w_echo_rise = r_echo_sync & ~r_echo_prev;
    assign w_echo_fall = ~r_echo_sync & r_echo_prev;
    assign w_pre_wrap  = (r_pre == c_PRE_LAST);

    // Accumulator value including this cycle's prescaler wrap, saturating so
    // a huge echo can never wrap back to a small range.
    always_comb begin
        w_acc_next = r_acc;
        if (w_pre_wrap && (r_acc != c_ALL_ONES)) begin
            w_acc_next = r_acc + c_ACC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pre      <= '0;
            r_acc      <= '0;
            triggerSuc <= 1'b0;
            valid      <= 1'b0;
            distance   <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
            sonar_trig <= 1'b0;
        end else begin
            triggerSuc <= 1'b0;
            valid      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_state    <= S_TRIG;
                        r_cnt      <= '0;
                        sonar_trig <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_TRIG: begin
                    if (r_cnt == c_TRIG_LAST) begin
                        sonar_trig <= 1'b0;
                        triggerSuc <= 1'b1;
                        r_state    <= S_WAIT_ECHO;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                // Only a rising edge starts a measurement, so an echo that is
                // already high on entry must fall and rise again first.
                S_WAIT_ECHO: begin
                    if (w_echo_rise) begin
                        r_state <= S_ECHO;
                        r_pre   <= '0;
                        r_acc   <= '0;
                        // The rise cycle is already the first high cycle.
                        r_cnt   <= c_CNT_ONE;
                    end else if (r_cnt == c_TOUT_LAST) begin
                        valid    <= 1'b1;
                        timeout  <= 1'b1;
                        distance <= c_ALL_ONES;
                        r_state  <= S_HOLDOFF;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                // The prescaler ticks once per ECHO cycle including the cycle
                // that sees the fall; that totals exactly the high width,
                // because the rise cycle itself is spent in WAIT_ECHO.
                // r_cnt holds the number of high cycles seen before this one.
                S_ECHO: begin
                    r_pre <= w_pre_wrap ? '0 : (r_pre + c_PRE_ONE);
                    r_acc <= w_acc_next;
                    if (w_echo_fall) begin
                        valid    <= 1'b1;
                        timeout  <= 1'b0;
                        distance <= w_acc_next;
                        r_state  <= S_HOLDOFF;
                        r_cnt    <= '0;
                    end else if (r_cnt == c_ECHO_LAST) begin
                        valid    <= 1'b1;
                        timeout  <= 1'b1;
                        distance <= c_ALL_ONES;
                        r_state  <= S_HOLDOFF;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                S_HOLDOFF: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    busy       <= 1'b0;
                    sonar_trig <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sonar_ranger.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_ranger
// Purpose  : Self-checking bench for sonar_ranger with shortened timing.
//            Echo pulses are placed relative to the triggerSuc cycle and the
//            result timing/value is predicted from the ranging rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonar_ranger;

    localparam int DL   = 16;
    localparam int TRIG = 5;
    localparam int CPM  = 4;
    localparam int TOUT = 50;
    localparam int MAXE = 100;
    localparam int HOLD = 10;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          trigger    = 1'b0;
    logic          sonar_echo = 1'b0;
    logic          triggerSuc;
    logic          valid;
    logic          timeout;
    logic          busy;
    logic          sonar_trig;
    logic [DL:0]   distance;

    int errors = 0;
    int checks = 0;

    sonar_ranger #(
        .DisLen      (DL),
        .TRIG_CYC    (TRIG),
        .CYC_PER_MM  (CPM),
        .TIMEOUT_CYC (TOUT),
        .MAX_ECHO_CYC(MAXE),
        .HOLDOFF_CYC (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .triggerSuc(triggerSuc),
        .valid     (valid),
        .distance  (distance),
        .timeout   (timeout),
        .busy      (busy),
        .sonar_trig(sonar_trig),
        .sonar_echo(sonar_echo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: cycle of the valid pulse counted from the triggerSuc cycle.
    // Echo driven high from offset dly is visible to the ranger two cycles
    // later; a rise must be seen within TOUT cycles of triggerSuc. A normal
    // result appears the cycle after the echo falls, an abort the cycle after
    // the MAXE-th high cycle.
    function automatic int exp_lat(input int dly, input int w);
        int rise;
        if (w == 0) return TOUT;
        rise = dly + 2;
        if (rise > TOUT - 1) return TOUT;
        if (w >= MAXE) return rise + MAXE;
        return rise + w + 1;
    endfunction

    function automatic bit exp_to(input int w);
        return (w == 0) || (w >= MAXE);
    endfunction

    function automatic logic [DL:0] exp_dist(input int w);
        logic [DL:0] ones;
        ones = '1;
        if (exp_to(w)) return ones;
        return (DL+1)'(w / CPM);
    endfunction

    // One measurement: stale = echo high from trigger until offset stale,
    // fresh echo from offset dly for w cycles (w=0: none). hold keeps
    // trigger high and measures the gap to the next sensor trigger.
    task automatic ping(input string name, input int stale, input int dly,
                        input int w, input bit hold);
        int n, hi, lat, got, to_obs, suc_extra, both, el, endi, gap;
        logic [DL:0] d_obs;
        trigger = 1'b1;
        if (stale > 0) sonar_echo = 1'b1;
        n = 0;
        while (!sonar_trig && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, ":trig_rise"}, sonar_trig, 1);
        hi = 0;
        while (sonar_trig && hi < 100) begin
            @(negedge clk);
            hi++;
        end
        chk({name, ":trig_len"}, hi, TRIG);
        chk({name, ":trig_suc"}, triggerSuc, 1);
        chk({name, ":busy"}, busy, 1);
        if (!hold) trigger = 1'b0;

        el   = exp_lat(dly, w);
        endi = ((el > dly + w) ? el : dly + w) + HOLD + 4;
        got = 0; lat = -1; to_obs = 0; d_obs = '0;
        suc_extra = 0; both = 0; gap = -1;
        for (int i = 0; i <= endi; i++) begin
            if (valid && triggerSuc) both++;
            if (i > 0 && triggerSuc) suc_extra++;
            if (valid) begin
                if (got == 0) begin
                    lat    = i;
                    d_obs  = distance;
                    to_obs = timeout;
                end
                got++;
            end
            if (hold && got > 0 && sonar_trig) begin
                gap = i - lat;
                break;
            end
            sonar_echo = (i < stale) || (i >= dly && i < dly + w);
            @(negedge clk);
        end
        sonar_echo = 1'b0;

        chk({name, ":valid_count"}, got, 1);
        chk({name, ":latency"}, lat, el);
        chk({name, ":timeout"}, to_obs, exp_to(w));
        chk({name, ":distance"}, d_obs, exp_dist(w));
        chk({name, ":distance_held"}, distance, exp_dist(w));
        chk({name, ":valid_suc_overlap"}, both, 0);
        chk({name, ":suc_once"}, suc_extra, 0);
        if (hold) chk({name, ":retrigger_gap"}, gap, HOLD + 1);
        else      chk({name, ":idle_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        trigger = 1'b0;
        sonar_echo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:valid", valid, 0);
        chk("rst:triggerSuc", triggerSuc, 0);
        chk("rst:distance", distance, 0);
        chk("rst:timeout", timeout, 0);
        chk("rst:busy", busy, 0);
        chk("rst:sonar_trig", sonar_trig, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle:busy", busy, 0);

        // Asynchronous reset in the middle of the trigger pulse.
        trigger = 1'b1;
        n = 0;
        while (!sonar_trig && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("midtrig:sonar_trig_high", sonar_trig, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midtrig:sonar_trig_drop", sonar_trig, 0);
        chk("midtrig:busy_drop", busy, 0);
        trigger = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        ping("w40",     0, 5, 40, 1'b0);
        ping("w43",     0, 3, 43, 1'b0);
        ping("w3",      0, 0, 3,  1'b0);
        ping("noecho",  0, 0, 0,  1'b0);
        ping("w120",    0, 4, 120, 1'b0);
        ping("stale",   3, 6, 20, 1'b1);
        ping("after",   0, 2, 8,  1'b0);
        for (int k = 0; k < 10; k++) begin
            ping("rand", 0, int'($urandom_range(0, 40)), int'($urandom_range(1, 130)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sonar_ranger.md
Name: sonar_ranger

Overview:
- Drives the ultrasonic range sensor on behalf of the cutting-machine controller.
- Converts a level trigger request into a timed sensor trigger pulse, then measures the echo pulse width.
- Returns the range in millimetres via a one-cycle valid strobe.
- Handles the echo timeout, excessive echo length and the minimum re-ping spacing, so the controller only sees the trigger/triggerSuc and valid/distance handshakes.

Parameters:
- DisLen, 16, distance bus is [DisLen:0].
- TRIG_CYC, 500, sensor trigger high time in clk cycles (10 us at 50 MHz).
- CYC_PER_MM, 291, clk cycles of echo per mm of range (round trip, 50 MHz).
- TIMEOUT_CYC, 1500000, maximum wait for echo rise after trigger.
- MAX_ECHO_CYC, 1250000, maximum echo high time before abort.
- HOLDOFF_CYC, 3000000, idle gap enforced after each result before the next ping.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- trigger, in, 1, measurement request (level, held by controller until triggerSuc).
- triggerSuc, out, 1, one-cycle pulse: sensor trigger pulse completed.
- valid, out, 1, one-cycle pulse: distance/timeout updated.
- distance, out, DisLen+1, range in mm, held between valids.
- timeout, out, 1, last result was a timeout/abort, held between valids.
- busy, out, 1, high whenever state != IDLE.
- sonar_trig, out, 1, sensor trigger pin.
- sonar_echo, in, 1, sensor echo pin (asynchronous).

Behaviour:
- Reset: async. All outputs 0, state IDLE, all counters 0. sonar_trig drops immediately on reset, including mid-operation.
- sonar_echo passes through a 2-flop synchronizer. Edges are detected on the synced signal. Both edges see the same delay, so width is preserved.
- All outputs are registered.
- States: IDLE, TRIG, WAIT_ECHO, ECHO, HOLDOFF.
- IDLE:
  - trigger is sampled only here.
  - trigger=1 -> TRIG; cycle counter cleared; sonar_trig=1 from the next cycle.
- TRIG:
  - sonar_trig stays high for exactly TRIG_CYC cycles.
  - In the first cycle sonar_trig is low again, triggerSuc=1 for that cycle only; state -> WAIT_ECHO with counter cleared.
- WAIT_ECHO:
  - On a synced rising edge -> ECHO; prescaler and distance accumulator cleared.
  - An echo already high on entry is stale and ignored until it falls and rises again.
  - If TIMEOUT_CYC cycles elapse with no rise: valid=1, timeout=1, distance=all-ones -> HOLDOFF.
- ECHO:
  - The prescaler counts 0..CYC_PER_MM-1. On each wrap the accumulator increments, saturating at all-ones.
  - Result: distance = floor(W/CYC_PER_MM), where W = number of cycles the synced echo is high.
  - On the synced falling edge: valid=1, distance=accumulator, timeout=0 -> HOLDOFF.
  - If W reaches MAX_ECHO_CYC: valid=1, timeout=1, distance=all-ones -> HOLDOFF. The later echo fall is ignored.
- HOLDOFF:
  - Counts HOLDOFF_CYC cycles, then -> IDLE.
  - A trigger held high during HOLDOFF starts TRIG on the first IDLE cycle.
- Trigger timing: trigger changes outside IDLE have no effect. Deassertion of trigger after triggerSuc is not required for correctness.
- Pulse exclusivity: valid and triggerSuc never assert in the same cycle. Exactly one valid follows each triggerSuc unless reset intervenes.
- Widths: each counter is sized by clog2 of its largest parameter. The accumulator is DisLen+1 bits with saturation; no wrap-around.

Test Plan (bench overrides: TRIG_CYC=5, CYC_PER_MM=4, TIMEOUT_CYC=50, MAX_ECHO_CYC=100, HOLDOFF_CYC=10):
- Reset, trigger=0, echo=0 -> all outputs 0, busy=0; async reset mid-TRIG drops sonar_trig in the same cycle.
- trigger=1 held -> sonar_trig high exactly 5 cycles, then triggerSuc one cycle; echo high 40 cycles -> valid one cycle, distance=10, timeout=0.
- Echo high 43 cycles -> distance=10 (floor); echo high 3 cycles -> distance=0, timeout=0.
- No echo after trigger -> 50 cycles after triggerSuc: valid, timeout=1, distance=17'h1FFFF.
- Echo held 120 cycles -> abort at W=100: valid, timeout=1, distance=all-ones; no second valid when echo falls.
- Echo high before triggerSuc and still high after -> ignored until a fresh rise. trigger held continuously -> next sonar_trig rises exactly 10 HOLDOFF cycles + 1 IDLE cycle after valid.
